avr_fetch_queue: RTL and testbench

Instruction prefetch queue that sits between the synchronous program memory and the `avr_cpu` decode/execute stage. It streams 16-bit words from program memory into a small FIFO and presents one complete instruction per cycle to the core, pairing 32-bit opcodes (LDS/STS/JMP/CALL) with their extension word. It also flushes and refetches on a control-flow redirect.

---
 rtl/avr_fetch_queue_if.sv | 25 ++
 rtl/avr_fetch_queue.sv | 125 ++++++++++++
 tb/tb_avr_fetch_queue.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/avr_fetch_queue_if.sv
// Bundle between avr_fetch_queue, the synchronous program memory and the avr_cpu core.
// The master modport belongs to the queue; the slave modport is the memory/core side.
interface avr_fetch_queue_if;
  logic [15:0] p_addr;
  logic        p_en;
  logic [15:0] p_data;
  logic [15:0] instr;
  logic [15:0] instr_ext;
  logic        instr_is32;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_take;
  logic        redirect;
  logic [15:0] redirect_pc;

  modport master (
    output p_addr, p_en, instr, instr_ext, instr_is32, instr_pc, instr_valid,
    input  p_data, instr_take, redirect, redirect_pc
  );

  modport slave (
    input  p_addr, p_en, instr, instr_ext, instr_is32, instr_pc, instr_valid,
    output p_data, instr_take, redirect, redirect_pc
  );
endinterface

// File: rtl/avr_fetch_queue.sv
// AVR instruction prefetch queue: streams program words into a small FIFO and presents one instruction per cycle.
// Define AVR_FETCH_QUEUE_LONG_EN to pair LDS/STS/JMP/CALL with their extension word; otherwise every word is 16-bit.
module avr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input logic              CLK,
  input logic              RST,
  avr_fetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

  logic [15:0]      fa_q, fa_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inf_q, inf_d;
  logic             kill_q, kill_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [15:0]      word_q [DEPTH];
  logic [15:0]      word_d [DEPTH];
  logic [15:0]      pc_q [DEPTH];
  logic [15:0]      pc_d [DEPTH];

  logic [15:0]      head_word;
  logic [15:0]      head_pc;
  logic [15:0]      head_ext;
  logic             has_head;
  logic             head_long;
  logic             head_valid;
  logic [CNT_W-1:0] pop_n;
  logic [CNT_W-1:0] count_pop;
  logic [CNT_W:0]   pending;
  logic             issue;
  logic             push;

  assign head_word = word_q[rd_q];
  assign head_pc   = pc_q[rd_q];
  assign has_head  = (count_q != '0);

`ifdef AVR_FETCH_QUEUE_LONG_EN
  function automatic logic is_long(input logic [15:0] w);
    is_long = ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000)) ||
              ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11));
  endfunction

  logic [PTR_W-1:0] rd_next;
  assign rd_next    = rd_q + PTR_W'(1);
  assign head_long  = has_head & is_long(head_word);
  assign head_valid = head_long ? (count_q >= CNT_W'(2)) : has_head;
  assign head_ext   = head_long ? word_q[rd_next] : 16'h0000;
`else
  assign head_long  = 1'b0;
  assign head_valid = has_head;
  assign head_ext   = 16'h0000;
`endif

  // Issue looks at occupancy after this cycle's pop and reserves a slot for the word still in flight.
  assign pop_n     = (head_valid & bus.instr_take) ? (head_long ? CNT_W'(2) : CNT_W'(1)) : '0;
  assign count_pop = count_q - pop_n;
  assign pending   = {1'b0, count_pop} + {{CNT_W{1'b0}}, inf_q};
  assign issue     = ~RST & ~bus.redirect & (pending < DEPTH_V);
  assign push      = inf_q & ~kill_q;

  assign bus.p_addr      = fa_q;
  assign bus.p_en        = issue;
  assign bus.instr       = has_head ? head_word : 16'h0000;
  assign bus.instr_pc    = has_head ? head_pc : 16'h0000;
  assign bus.instr_is32  = head_long;
  assign bus.instr_ext   = head_ext;
  assign bus.instr_valid = head_valid;

  // A redirect discards the queue contents and any pending take; nothing is issued in that cycle.
  always_comb begin
    fa_d    = fa_q;
    count_d = count_q;
    inf_d   = issue;
    kill_d  = 1'b0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    word_d  = word_q;
    pc_d    = pc_q;
    if (bus.redirect) begin
      count_d = '0;
      rd_d    = wr_q;
      fa_d    = bus.redirect_pc;
      kill_d  = inf_q;
    end else begin
      if (issue) begin
        fa_d = fa_q + 16'd1;
      end
      if (push) begin
        word_d[wr_q] = bus.p_data;
        pc_d[wr_q]   = fa_q - 16'd1;
        wr_d         = wr_q + PTR_W'(1);
      end
      count_d = count_pop + {{(CNT_W-1){1'b0}}, push};
      rd_d    = rd_q + pop_n[PTR_W-1:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fa_q    <= 16'h0000;
      count_q <= '0;
      inf_q   <= 1'b0;
      kill_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      word_q  <= '{default: '0};
      pc_q    <= '{default: '0};
    end else begin
      fa_q    <= fa_d;
      count_q <= count_d;
      inf_q   <= inf_d;
      kill_q  <= kill_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_avr_fetch_queue.sv
// Directed bench for avr_fetch_queue: a program-memory model, an instruction-stream reference model,
// and hand-computed expectations for reset, stall, redirect, long-opcode pairing and address wrap.
module tb_avr_fetch_queue;

  localparam int DEPTH = 4;
`ifdef AVR_FETCH_QUEUE_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  bit          jmp_mode;
  int          checks;
  int          errors;
  int          pen_count;
  logic [15:0] model_pc;
  logic [15:0] m_word;
  bit          m_long;
  logic [15:0] seen_pc[$];
  logic [15:0] seen_instr[$];
  logic [15:0] seen_ext[$];
  bit          seen_long[$];

  avr_fetch_queue_if bus();

  avr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  // Program image: address XOR A5A5, with a JMP 0x1234 planted at words 2/3 when jmp_mode is set.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (jmp_mode && a == 16'h0002) return 16'h940C;
    if (jmp_mode && a == 16'h0003) return 16'h1234;
    return a ^ 16'hA5A5;
  endfunction

  function automatic bit is_long_op(input logic [15:0] w);
    bit lds, sts, jmp, call;
    lds  = (w[15:9] == 7'b1001000) && (w[3:0] == 4'b0000);
    sts  = (w[15:9] == 7'b1001001) && (w[3:0] == 4'b0000);
    jmp  = (w[15:9] == 7'b1001010) && (w[3:1] == 3'b110);
    call = (w[15:9] == 7'b1001010) && (w[3:1] == 3'b111);
    return LONG_EN && (lds || sts || jmp || call);
  endfunction

  always @(posedge CLK) begin
    bus.p_data <= bus.p_en ? mem_word(bus.p_addr) : 16'hDEAD;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst_v, input bit take_v, input bit redir_v, input logic [15:0] rpc_v);
    @(negedge CLK);
    RST             = rst_v;
    bus.instr_take  = take_v;
    bus.redirect    = redir_v;
    bus.redirect_pc = rpc_v;
    #3;
    if (!RST && bus.instr_valid && take_v && !redir_v) begin
      seen_pc.push_back(bus.instr_pc);
      seen_instr.push_back(bus.instr);
      seen_ext.push_back(bus.instr_ext);
      seen_long.push_back(bus.instr_is32);
    end
  endtask

  task automatic clearSeen();
    seen_pc.delete();
    seen_instr.delete();
    seen_ext.delete();
    seen_long.delete();
  endtask

  // Reference model: the next instruction the core must see is the program word at model_pc.
  always begin
    @(negedge CLK);
    #2;
    if (RST) begin
      checkOutput("rst_hold_valid", 16'(bus.instr_valid), 16'h0000);
      checkOutput("rst_hold_p_en", 16'(bus.p_en), 16'h0000);
      model_pc = 16'h0000;
    end else begin
      m_word = mem_word(model_pc);
      m_long = is_long_op(m_word);
      if (bus.instr_valid) begin
        checkOutput("model_pc", bus.instr_pc, model_pc);
        checkOutput("model_instr", bus.instr, m_word);
        checkOutput("model_is32", 16'(bus.instr_is32), 16'(m_long));
        checkOutput("model_ext", bus.instr_ext, m_long ? mem_word(model_pc + 16'd1) : 16'h0000);
      end
      if (bus.redirect) model_pc = bus.redirect_pc;
      else if (bus.instr_valid && bus.instr_take) model_pc = model_pc + 16'(m_long ? 2 : 1);
    end
  end

  initial begin
    checks          = 0;
    errors          = 0;
    jmp_mode        = 1'b0;
    model_pc        = 16'h0000;
    RST             = 1'b1;
    bus.instr_take  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("rst_p_en", 16'(bus.p_en), 16'h0000);
    checkOutput("rst_p_addr", bus.p_addr, 16'h0000);
    checkOutput("rst_valid", 16'(bus.instr_valid), 16'h0000);
    checkOutput("rst_instr", bus.instr, 16'h0000);
    checkOutput("rst_pc", bus.instr_pc, 16'h0000);
    checkOutput("rst_is32", 16'(bus.instr_is32), 16'h0000);
    checkOutput("rst_ext", bus.instr_ext, 16'h0000);

    $display("[TB] reset release, streaming with take=1");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("c0_p_en", 16'(bus.p_en), 16'h0001);
    checkOutput("c0_p_addr", bus.p_addr, 16'h0000);
    checkOutput("c0_valid", 16'(bus.instr_valid), 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("c1_valid", 16'(bus.instr_valid), 16'h0000);
    checkOutput("c1_p_addr", bus.p_addr, 16'h0001);
    for (int k = 2; k < 12; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput("stream_valid", 16'(bus.instr_valid), 16'h0001);
      checkOutput("stream_pc", bus.instr_pc, 16'(k - 2));
      checkOutput("stream_instr", bus.instr, 16'(k - 2) ^ 16'hA5A5);
    end

    $display("[TB] core stall for 10 cycles");
    pen_count = 0;
    for (int s = 0; s < 10; s++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      if (bus.p_en) pen_count++;
    end
    checkOutput("stall_fetches", 16'(pen_count), 16'(DEPTH - 2));
    checkOutput("stall_p_en", 16'(bus.p_en), 16'h0000);
    checkOutput("stall_head_pc", bus.instr_pc, 16'h000A);
    clearSeen();
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("resume_len", 16'(seen_pc.size()), 16'h0006);
    for (int i = 0; i < 4 && i < seen_pc.size(); i++) begin
      checkOutput("resume_order", seen_pc[i], 16'(10 + i));
    end

    $display("[TB] redirect to 0x0040 with a full queue and a read in flight");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0040);
    checkOutput("redir_n_p_en", 16'(bus.p_en), 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("redir_n1_p_en", 16'(bus.p_en), 16'h0001);
    checkOutput("redir_n1_p_addr", bus.p_addr, 16'h0040);
    checkOutput("redir_n1_valid", 16'(bus.instr_valid), 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("redir_n2_valid", 16'(bus.instr_valid), 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("redir_n3_valid", 16'(bus.instr_valid), 16'h0001);
    checkOutput("redir_n3_pc", bus.instr_pc, 16'h0040);
    checkOutput("redir_n3_instr", bus.instr, 16'hA5E5);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

    $display("[TB] asynchronous reset with three words held and one in flight");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge CLK);
    bus.instr_take = 1'b0;
    #1;
    RST = 1'b1;
    #3;
    checkOutput("async_p_en", 16'(bus.p_en), 16'h0000);
    checkOutput("async_p_addr", bus.p_addr, 16'h0000);
    checkOutput("async_valid", 16'(bus.instr_valid), 16'h0000);
    checkOutput("async_instr", bus.instr, 16'h0000);
    checkOutput("async_pc", bus.instr_pc, 16'h0000);
    jmp_mode = 1'b1;
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);

    $display("[TB] restart with JMP 0x1234 at word 2");
    clearSeen();
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("jmp_len_ok", 16'(seen_pc.size() >= 4), 16'h0001);
    if (seen_pc.size() >= 4) begin
      checkOutput("jmp_pc0", seen_pc[0], 16'h0000);
      checkOutput("jmp_pc1", seen_pc[1], 16'h0001);
      checkOutput("jmp_pc2", seen_pc[2], 16'h0002);
      checkOutput("jmp_instr", seen_instr[2], 16'h940C);
      checkOutput("jmp_is32", 16'(seen_long[2]), 16'(LONG_EN));
      checkOutput("jmp_ext", seen_ext[2], LONG_EN ? 16'h1234 : 16'h0000);
      checkOutput("jmp_next_pc", seen_pc[3], LONG_EN ? 16'h0004 : 16'h0003);
    end

    $display("[TB] back-to-back redirects, then fetch across the address wrap");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0100);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFE);
    clearSeen();
    repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("wrap_len_ok", 16'(seen_pc.size() >= 3), 16'h0001);
    if (seen_pc.size() >= 3) begin
      checkOutput("wrap_pc0", seen_pc[0], 16'hFFFE);
      checkOutput("wrap_instr0", seen_instr[0], 16'h5A5B);
      checkOutput("wrap_pc1", seen_pc[1], 16'hFFFF);
      checkOutput("wrap_pc2", seen_pc[2], 16'h0000);
    end

    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
